pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control unit for the 32-bit RISC-V five-stage core. It produces the enable and flush controls for the PC register, the IF/ID register and the ID/EX register. It resolves four conditions into those controls by fixed priority: taken-branch/jump redirects, multi-cycle EX operations, load-use hazards and instruction-fetch wait states. It also keeps stall and flush statistics and flags a hung multi-cycle unit.

## Interface
Parameters:
- `DATAWIDTH`, 32: counter width.
- `MC_TIMEOUT`, 64: cycles in MC_WAIT before `mc_timeout` sets.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `id_rs1`, `id_rs2`  in  5  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  a taken branch or jump resolved in EX this cycle.
- `mc_start`  in  1  a multi-cycle op (mul/div) is in EX, first cycle.
- `mc_done`  in  1  the multi-cycle result is valid this cycle.
- `imem_ready`  in  1  fetch data is valid this cycle.
- `pc_en`  out  1  PC register load enable.
- `ifid_en`  out  1  IF/ID register enable.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `idex_en`  out  1  ID/EX register enable.
- `idex_flush`  out  1  load bubble into ID/EX.
- `exmem_flush`  out  1  load bubble into EX/MEM.
- `mc_timeout`  out  1  sticky hang flag.
- `stall_cnt`  out  DATAWIDTH  count of cycles with `pc_en`=0.
- `flush_cnt`  out  DATAWIDTH  count of redirect events.

## Operation
- **FSM states:** INIT, RUN, MC_WAIT.
  - `rst` → INIT.
  - INIT → RUN unconditionally.
  - RUN → MC_WAIT on `mc_start` with `mc_done`=0.
  - MC_WAIT → RUN on `mc_done`.
- **Load-use detect (`lu`):** `ex_mem_read` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- **Default outputs in RUN:** `pc_en`=`ifid_en`=`idex_en`=1; all flushes 0.
- **RUN priority** (the first matching rule wins):
  1. `ex_redirect`: `pc_en`=1, `ifid_flush`=1, `idex_flush`=1; `flush_cnt`+1.
  2. `mc_start` & !`mc_done`: `pc_en`=0, `ifid_en`=0, `idex_en`=0, `exmem_flush`=1.
  3. `lu`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  4. !`imem_ready`: `pc_en`=0, `ifid_flush`=1.
- **INIT:** `pc_en`=0, `ifid_flush`=1, `idex_flush`=1, `exmem_flush`=1.
- **MC_WAIT, `mc_done`=0:** outputs as rule 2.
- **MC_WAIT, `mc_done`=1:** default outputs, and the pipeline advances.
- **Inputs ignored in MC_WAIT:** `ex_redirect`, `lu`, `imem_ready`.
- **`mc_start` & `mc_done` in the same RUN cycle:** a one-cycle op. No stall, no state change, and rules 3–4 still apply.
- **Watchdog:** counts cycles spent in MC_WAIT and clears on entry.
  - Reaching `MC_TIMEOUT` sets `mc_timeout`.
  - `mc_timeout` is cleared only by `rst`.
  - The FSM stays in MC_WAIT.
- **Counters:** wrap at 2^DATAWIDTH.

## Timing
- Every control output is combinational from the state register and the same-cycle inputs, so it takes effect at the next `clk` edge.
- **During `rst`:** outputs equal the INIT values and `mc_timeout`=0.
- **The cycle after `rst` falls:** state is INIT, `stall_cnt` and `flush_cnt` are 0, and outputs are the INIT values.
- **Counter update:** `stall_cnt` and `flush_cnt` register at the same edge as the event.
  - INIT cycles count toward `stall_cnt`.
  - Cycles with `rst` high do not count.
- **Load-use:** exactly one bubble. Next cycle the load sits in MEM and `lu` deasserts with no state.
- **Multi-cycle stall:** N cycles of stall for `mc_done` arriving N cycles after `mc_start`.
- **Reset in MC_WAIT:** `rst` returns the FSM to INIT, clears both counters and the watchdog, and clears `mc_timeout`.

## Structure
- **Shared package `riscv_pipe_pkg`:** holds the FSM state enum (INIT/RUN/MC_WAIT), `REG_AW`=5 and the x0 index constant.
- **Sub-module `load_use_det`:** the combinational `lu` compare. The main module holds the FSM, the priority mux, the watchdog and the counters.

## Test plan
- **Reset release:** hold `rst` 3 cycles, then release.
  - Cycle 1 after release: `pc_en`=0, all flushes 1.
  - Cycle 2: RUN with default outputs.
  - `stall_cnt`=1 after the INIT edge.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for 1 cycle.
  - `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for exactly that cycle.
  - `stall_cnt` increments by 1.
  - Same stimulus with `ex_rd`=0 → no stall.
- **Redirect vs load-use:** `ex_redirect`=1 together with a load-use match.
  - Response: `pc_en`=1, `ifid_flush`=1, `idex_flush`=1; `flush_cnt` increments by 1 and `stall_cnt` is unchanged.
- **Multi-cycle:** `mc_start` at cycle 0, `mc_done` at cycle 4.
  - Cycles 0–3: stall outputs with `exmem_flush`=1.
  - Cycle 4: defaults, and the state returns to RUN.
  - `stall_cnt` increments by 4.
  - `ex_redirect` pulsed at cycle 2 has no effect.
- **Watchdog:** `MC_TIMEOUT`=8, `mc_start` with no `mc_done`.
  - `mc_timeout` rises after 8 MC_WAIT cycles and stays high.
  - `rst` clears it and returns the FSM to INIT.
- **Fetch wait:** `imem_ready`=0 for 3 cycles in RUN.
  - `pc_en`=0, `ifid_flush`=1, `ifid_en`=1 for those 3 cycles.
  - `stall_cnt` increments by 3.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types for the five-stage RISC-V core.
// Holds the hazard FSM state, register-index width and stage controls.
package riscv_pipe_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    MC_WAIT
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_flush;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the
// hazard unit: hazard sources in, stage enables/flushes out.
interface pipe_hazard_ctrl_if #(
  parameter int DATAWIDTH = 32
);
  import riscv_pipe_pkg::*;

  logic [REG_AW-1:0]    id_rs1;
  logic [REG_AW-1:0]    id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [REG_AW-1:0]    ex_rd;
  logic                 ex_mem_read;
  logic                 ex_redirect;
  logic                 mc_start;
  logic                 mc_done;
  logic                 imem_ready;

  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_en;
  logic                 idex_flush;
  logic                 exmem_flush;
  logic                 mc_timeout;
  logic [DATAWIDTH-1:0] stall_cnt;
  logic [DATAWIDTH-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_mem_read, ex_redirect,
    output mc_start, mc_done, imem_ready,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_en, idex_flush, exmem_flush,
    input  mc_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_mem_read, ex_redirect,
    input  mc_start, mc_done, imem_ready,
    output pc_en, ifid_en, ifid_flush,
    output idex_en, idex_flush, exmem_flush,
    output mc_timeout, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
// Load-use detector: the load in EX writes a register that the
// instruction in ID reads; x0 never creates a dependency.
module load_use_det
  import riscv_pipe_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              lu
);

  logic hit1;
  logic hit2;

  assign hit1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 && (id_rs2 == ex_rd);
  assign lu   = ex_mem_read && (ex_rd != REG_X0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: priority mux for PC/IF/ID/EX enables and
// flushes, multi-cycle wait FSM, hang watchdog and stall/flush stats.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int MC_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WDW = $clog2(MC_TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(MC_TIMEOUT - 1);

  localparam hz_ctrl_t CTL_DEF   = 6'b110100;
  localparam hz_ctrl_t CTL_INIT  = 6'b011111;
  localparam hz_ctrl_t CTL_REDIR = 6'b111110;
  localparam hz_ctrl_t CTL_MC    = 6'b000001;
  localparam hz_ctrl_t CTL_LU    = 6'b000110;
  localparam hz_ctrl_t CTL_FETCH = 6'b011100;

  hz_state_e            state;
  logic [WDW-1:0]       wd_cnt;
  logic                 to_q;
  logic [DATAWIDTH-1:0] stall_q;
  logic [DATAWIDTH-1:0] flush_q;

  logic     lu;
  logic     redir;
  logic     mc_enter;
  hz_ctrl_t ctl;

  load_use_det u_lu (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .lu          (lu)
  );

  // Reset forces the INIT controls so the pipeline is bubbled
  // even before the state register has been cleared.
  always_comb begin
    ctl      = CTL_DEF;
    redir    = 1'b0;
    mc_enter = 1'b0;
    if (rst || state == INIT) begin
      ctl = CTL_INIT;
    end else if (state == MC_WAIT) begin
      if (!bus.mc_done) ctl = CTL_MC;
    end else if (bus.ex_redirect) begin
      ctl   = CTL_REDIR;
      redir = 1'b1;
    end else if (bus.mc_start && !bus.mc_done) begin
      ctl      = CTL_MC;
      mc_enter = 1'b1;
    end else if (lu) begin
      ctl = CTL_LU;
    end else if (!bus.imem_ready) begin
      ctl = CTL_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      wd_cnt  <= '0;
      to_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctl.pc_en) stall_q <= stall_q + DATAWIDTH'(1);
      if (redir)      flush_q <= flush_q + DATAWIDTH'(1);
      unique case (state)
        INIT: state <= RUN;
        RUN: begin
          if (mc_enter) begin
            state  <= MC_WAIT;
            wd_cnt <= '0;
          end
        end
        MC_WAIT: begin
          if (bus.mc_done) begin
            state <= RUN;
          end else if (!to_q) begin
            wd_cnt <= wd_cnt + WDW'(1);
            if (wd_cnt == WD_LAST) to_q <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.pc_en       = ctl.pc_en;
  assign bus.ifid_en     = ctl.ifid_en;
  assign bus.ifid_flush  = ctl.ifid_flush;
  assign bus.idex_en     = ctl.idex_en;
  assign bus.idex_flush  = ctl.idex_flush;
  assign bus.exmem_flush = ctl.exmem_flush;
  assign bus.mc_timeout  = to_q && !rst;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then random traffic against a rule-level model.
module tb_pipe_hazard_ctrl;

  localparam int TO = 8;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_hazard_ctrl_if #(.DATAWIDTH(32)) bus ();

  pipe_hazard_ctrl #(
    .DATAWIDTH  (32),
    .MC_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pipeline phase flags, wait length, stats.
  logic        m_valid = 1'b0;
  logic        m_init  = 1'b1;
  logic        m_wait  = 1'b0;
  int          m_wd    = 0;
  logic        m_to    = 1'b0;
  logic [31:0] m_st    = '0;
  logic [31:0] m_fl    = '0;
  logic        m_lu;
  logic [5:0]  m_ctl;

  // Control word order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_flush
  function automatic logic [5:0] model_ctl(
    input logic r, input logic init, input logic wt,
    input logic luv, input logic redir, input logic st,
    input logic dn, input logic rdy
  );
    if (r || init)       return 6'b011111;
    if (wt)              return dn ? 6'b110100 : 6'b000001;
    if (redir)           return 6'b111110;
    if (st && !dn)       return 6'b000001;
    if (luv)             return 6'b000110;
    if (!rdy)            return 6'b011100;
    return 6'b110100;
  endfunction

  assign m_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                 (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));

  assign m_ctl = model_ctl(rst, m_init, m_wait, m_lu, bus.ex_redirect,
                           bus.mc_start, bus.mc_done, bus.imem_ready);

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_init <= 1'b1;
      m_wait <= 1'b0;
      m_wd   <= 0;
      m_to   <= 1'b0;
      m_st   <= '0;
      m_fl   <= '0;
    end else begin
      if (!m_ctl[5]) m_st <= m_st + 1;
      if (m_init) begin
        m_init <= 1'b0;
      end else if (m_wait) begin
        if (bus.mc_done) m_wait <= 1'b0;
        else if (!m_to) begin
          m_wd <= m_wd + 1;
          if (m_wd + 1 == TO) m_to <= 1'b1;
        end
      end else if (bus.ex_redirect) begin
        m_fl <= m_fl + 1;
      end else if (bus.mc_start && !bus.mc_done) begin
        m_wait <= 1'b1;
        m_wd   <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_chk++;
      if ({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
           bus.idex_flush, bus.exmem_flush} !== m_ctl) begin
        n_fail++;
        $display("FAIL ctl t=%0t got %b want %b", $time,
                 {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                  bus.idex_flush, bus.exmem_flush}, m_ctl);
      end
      n_chk++;
      if (bus.mc_timeout !== (m_to && !rst)) begin
        n_fail++;
        $display("FAIL mc_timeout t=%0t got %b want %b", $time,
                 bus.mc_timeout, m_to && !rst);
      end
      n_chk++;
      if (bus.stall_cnt !== m_st) begin
        n_fail++;
        $display("FAIL stall_cnt t=%0t got %0d want %0d", $time,
                 bus.stall_cnt, m_st);
      end
      n_chk++;
      if (bus.flush_cnt !== m_fl) begin
        n_fail++;
        $display("FAIL flush_cnt t=%0t got %0d want %0d", $time,
                 bus.flush_cnt, m_fl);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1      = 5'd1;
    bus.id_rs2      = 5'd2;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_mem_read = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.mc_start    = 1'b0;
    bus.mc_done     = 1'b0;
    bus.imem_ready  = 1'b1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = rd;
    bus.id_rs2      = 5'd5;
    bus.id_use_rs2  = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("init_pc_en", 32'(bus.pc_en), 0);
    chk("init_ifid_flush", 32'(bus.ifid_flush), 1);
    chk("init_idex_flush", 32'(bus.idex_flush), 1);
    chk("init_exmem_flush", 32'(bus.exmem_flush), 1);
    chk("init_stall_cnt", bus.stall_cnt, 0);
    tick();
    @(negedge clk);
    chk("run_pc_en", 32'(bus.pc_en), 1);
    chk("run_ifid_flush", 32'(bus.ifid_flush), 0);
    chk("run_stall_cnt", bus.stall_cnt, 1);

    tick();
    set_lu(5'd5);
    @(negedge clk);
    chk("lu_pc_en", 32'(bus.pc_en), 0);
    chk("lu_ifid_en", 32'(bus.ifid_en), 0);
    chk("lu_idex_flush", 32'(bus.idex_flush), 1);
    tick();
    idle();
    @(negedge clk);
    chk("lu_after_pc_en", 32'(bus.pc_en), 1);
    chk("lu_stall_cnt", bus.stall_cnt, 2);

    tick();
    set_lu(5'd0);
    bus.id_rs2 = 5'd0;
    @(negedge clk);
    chk("x0_pc_en", 32'(bus.pc_en), 1);
    chk("x0_idex_flush", 32'(bus.idex_flush), 0);
    tick();
    idle();
    @(negedge clk);
    chk("x0_stall_cnt", bus.stall_cnt, 2);

    tick();
    set_lu(5'd5);
    bus.ex_redirect = 1'b1;
    @(negedge clk);
    chk("redir_pc_en", 32'(bus.pc_en), 1);
    chk("redir_ifid_flush", 32'(bus.ifid_flush), 1);
    chk("redir_idex_flush", 32'(bus.idex_flush), 1);
    tick();
    idle();
    @(negedge clk);
    chk("redir_flush_cnt", bus.flush_cnt, 1);
    chk("redir_stall_cnt", bus.stall_cnt, 2);

    tick();
    bus.mc_start = 1'b1;
    @(negedge clk);
    chk("mc0_pc_en", 32'(bus.pc_en), 0);
    chk("mc0_ifid_en", 32'(bus.ifid_en), 0);
    chk("mc0_exmem_flush", 32'(bus.exmem_flush), 1);
    tick();
    bus.mc_start = 1'b0;
    @(negedge clk);
    chk("mc1_pc_en", 32'(bus.pc_en), 0);
    tick();
    bus.ex_redirect = 1'b1;
    @(negedge clk);
    chk("mc2_pc_en", 32'(bus.pc_en), 0);
    chk("mc2_ifid_flush", 32'(bus.ifid_flush), 0);
    chk("mc2_idex_en", 32'(bus.idex_en), 0);
    tick();
    bus.ex_redirect = 1'b0;
    @(negedge clk);
    chk("mc3_exmem_flush", 32'(bus.exmem_flush), 1);
    tick();
    bus.mc_done = 1'b1;
    @(negedge clk);
    chk("mc4_pc_en", 32'(bus.pc_en), 1);
    chk("mc4_exmem_flush", 32'(bus.exmem_flush), 0);
    tick();
    bus.mc_done = 1'b0;
    @(negedge clk);
    chk("mc5_pc_en", 32'(bus.pc_en), 1);
    chk("mc_stall_cnt", bus.stall_cnt, 6);
    chk("mc_flush_cnt", bus.flush_cnt, 1);

    tick();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fw_pc_en", 32'(bus.pc_en), 0);
      chk("fw_ifid_flush", 32'(bus.ifid_flush), 1);
      chk("fw_ifid_en", 32'(bus.ifid_en), 1);
      if (i < 2) tick();
    end
    tick();
    bus.imem_ready = 1'b1;
    @(negedge clk);
    chk("fw_stall_cnt", bus.stall_cnt, 9);

    tick();
    bus.mc_start = 1'b1;
    @(negedge clk);
    tick();
    bus.mc_start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("wd_low", 32'(bus.mc_timeout), 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_high", 32'(bus.mc_timeout), 1);
      chk("wd_pc_en", 32'(bus.pc_en), 0);
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("wd_rst_to", 32'(bus.mc_timeout), 0);
    chk("wd_rst_exmem", 32'(bus.exmem_flush), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("wd_init_pc_en", 32'(bus.pc_en), 0);
    chk("wd_init_stall", bus.stall_cnt, 0);
    chk("wd_init_flush", bus.flush_cnt, 0);

    for (int c = 0; c < 3000; c++) begin
      tick();
      rst             = ($urandom_range(0, 99) == 0);
      bus.id_rs1      = 5'($urandom_range(0, 7));
      bus.id_rs2      = 5'($urandom_range(0, 7));
      bus.id_use_rs1  = 1'($urandom_range(0, 1));
      bus.id_use_rs2  = 1'($urandom_range(0, 1));
      bus.ex_rd       = 5'($urandom_range(0, 7));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_redirect = ($urandom_range(0, 7) == 0);
      bus.mc_start    = ($urandom_range(0, 9) == 0);
      bus.mc_done     = ($urandom_range(0, 5) == 0);
      bus.imem_ready  = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
